// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the MEM-stage SRAM controller:
//               FSM state encoding, default address map constants and the
//               byte-address to SRAM-word translation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Byte address that maps onto SRAM word 0, and SRAM data-bus width.
  localparam int unsigned MEM_ADDR_BASE_DEF = 1024;
  localparam int unsigned MEM_SRAM_DW       = 16;

  // Access sequencer states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LO   = 2'd1;
  localparam state_t ST_HI   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Full 32-bit word index; the caller keeps only as many low bits as the
  // SRAM has words, so out-of-range addresses wrap modulo the SRAM size.
  function automatic logic [31:0] xlate_word(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Wait-state counter. Counts 0..WAIT_CYCLES-1 while clear is
//               low, flags the terminal count on done and wraps to 0 after it.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous active-high reset
//               clear - hold count at 0
//               done  - count is at its terminal value (WAIT_CYCLES-1)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam logic [3:0] C_TERM = 4'(WAIT_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign done = (cnt_q == C_TERM);

  // Wrapping on done clears the count at the same edge the FSM moves on.
  always_comb begin
    cnt_d = cnt_q + 4'd1;
    if (clear || done) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_ctrl
// Description : MEM-stage load/store unit for a 16-bit asynchronous SRAM.
//               Each 32-bit access is split into a low and a high half-word
//               access of WAIT_CYCLES clocks each; ready is held low to
//               freeze the pipeline until the access completes.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               mem_r_en, mem_w_en  - load / store request (read wins)
//               address, write_data - byte address and store data
//               read_data           - registered load result
//               ready               - 1 = MEM stage may advance
//               sram_addr, sram_dq_o, sram_dq_i, sram_dq_oe,
//               sram_we_n, sram_ce_n - SRAM interface (outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = MEM_ADDR_BASE_DEF,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_o,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_ce_n
);

  localparam int unsigned C_WORD_W = SRAM_ADDR_W - 1;

  state_t                state_q, state_d;
  logic                  op_rd_q, op_rd_d;
  logic [C_WORD_W-1:0]   word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]           dq_o_q, dq_o_d;
  logic                  oe_q, oe_d;
  logic                  we_n_q, we_n_d;
  logic                  ce_n_q, ce_n_d;

  logic                  req;
  logic [31:0]           xlate_full;
  logic [C_WORD_W-1:0]   new_word;
  logic                  unused_xlate;
  logic                  cnt_clear;
  logic                  cnt_done;

  assign req          = mem_r_en | mem_w_en;
  assign xlate_full   = xlate_word(address, 32'(ADDR_BASE));
  assign new_word     = xlate_full[C_WORD_W-1:0];
  assign unused_xlate = ^xlate_full[31:C_WORD_W];

  // The counter only runs during the two half-word phases.
  assign cnt_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .done  (cnt_done)
  );

  // SRAM strobes are computed one cycle ahead so they are registered and
  // already valid on the first cycle of each phase.
  always_comb begin
    state_d     = state_q;
    op_rd_d     = op_rd_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    oe_d        = oe_q;
    we_n_d      = we_n_q;
    ce_n_d      = ce_n_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d     = ST_LO;
          op_rd_d     = mem_r_en;
          word_d      = new_word;
          wdata_d     = write_data;
          sram_addr_d = {new_word, 1'b0};
          dq_o_d      = write_data[15:0];
          ce_n_d      = 1'b0;
          we_n_d      = mem_r_en;   // read has priority: no write strobe
          oe_d        = ~mem_r_en;
        end
      end
      ST_LO: begin
        if (cnt_done) begin
          if (op_rd_q) begin
            read_data_d[15:0] = sram_dq_i;
          end
          state_d     = ST_HI;
          sram_addr_d = {word_q, 1'b1};
          dq_o_d      = wdata_q[31:16];
        end
      end
      ST_HI: begin
        if (cnt_done) begin
          if (op_rd_q) begin
            read_data_d[31:16] = sram_dq_i;
          end
          state_d = ST_DONE;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          oe_d    = 1'b0;
        end
      end
      ST_DONE: begin
        // Requests seen here belong to the instruction now completing.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_rd_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_rd_q     <= op_rd_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
      ce_n_q      <= ce_n_d;
    end
  end

  assign ready      = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign read_data  = read_data_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = oe_q;
  assign sram_we_n  = we_n_q;
  assign sram_ce_n  = ce_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_sram_ctrl
// Description : Self-checking bench for mem_stage_sram_ctrl. An SRAM array
//               answers the controller; a separate sparse reference memory
//               predicts load results and the expected bus sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n, sram_ce_n;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] sram_env [0:(1<<AW)-1];
  logic [15:0] ref_mem [int unsigned];
  logic [31:0] last_rd;

  mem_stage_sram_ctrl #(
    .ADDR_BASE   (BASE),
    .SRAM_ADDR_W (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_ce_n  (sram_ce_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write committed while strobed.
  assign sram_dq_i = sram_env[sram_addr];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) sram_env[sram_addr] <= sram_dq_o;
  end

  function automatic logic [15:0] ref_get(input int unsigned i);
    return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_ce_n", 32'(sram_ce_n), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
    end
  endtask

  // One complete access; returns at the negedge of the ready-high cycle
  // with the request still applied, so a follow-up call runs back-to-back.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd);
    bit          is_wr;
    bit          hi;
    bit          done;
    logic [31:0] diff;
    int unsigned word, lo_a, hi_a;
    logic [31:0] exp_rd;
    int          c;
    is_wr = w && !r;
    diff  = a - 32'(BASE);
    word  = (diff >> 2) % (1 << (AW - 1));
    lo_a  = word * 2;
    hi_a  = word * 2 + 1;
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; address = a; write_data = wd;
    c = 0; done = 0;
    while (!done && c < 4 * W + 8) begin
      @(negedge clk);
      if (c == 0) begin
        chk("req_ready", 32'(ready), 32'd0);
        chk("req_ce_n", 32'(sram_ce_n), 32'd1);
      end else if (c <= 2 * W) begin
        hi = (c > W);
        chk("acc_ready", 32'(ready), 32'd0);
        chk("acc_ce_n", 32'(sram_ce_n), 32'd0);
        chk("acc_we_n", 32'(sram_we_n), 32'(!is_wr));
        chk("acc_oe", 32'(sram_dq_oe), 32'(is_wr));
        chk("acc_addr", 32'(sram_addr), hi ? hi_a : lo_a);
        if (is_wr) chk("acc_dq_o", 32'(sram_dq_o), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
      end else begin
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_ce_n", 32'(sram_ce_n), 32'd1);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe", 32'(sram_dq_oe), 32'd0);
        if (r) begin
          exp_rd = {ref_get(hi_a), ref_get(lo_a)};
          chk("read_data", read_data, exp_rd);
          last_rd = exp_rd;
        end else begin
          chk("read_data_hold", read_data, last_rd);
        end
        done = 1;
      end
      c++;
    end
    if (is_wr) begin
      ref_mem[lo_a] = wd[15:0];
      ref_mem[hi_a] = wd[31:16];
    end
  endtask

  initial begin
    int unsigned op, gap;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) sram_env[i] = 16'h0000;
    last_rd = 32'h0;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; write_data = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_o", 32'(sram_dq_o), 32'h0);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    @(posedge clk); #1; rst = 1'b0;

    idle(4);

    // Directed write/read pair, then a write that must not touch read_data
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    idle(1);
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    idle(1);
    access(1'b0, 1'b1, 32'd1032, 32'h12345678);
    idle(1);

    // Back-to-back: read then write with no idle gap
    access(1'b1, 1'b0, 32'd1032, 32'h0);
    access(1'b0, 1'b1, 32'd1036, 32'hA5A55A5A);
    access(1'b1, 1'b0, 32'd1036, 32'h0);
    idle(2);

    // Reset in the second LO cycle of a write
    @(posedge clk); #1;
    mem_w_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b1; mem_w_en = 1'b0;
    #1;
    chk("async_we_n", 32'(sram_we_n), 32'd1);
    chk("async_ce_n", 32'(sram_ce_n), 32'd1);
    chk("async_oe", 32'(sram_dq_oe), 32'd0);
    chk("async_read_data", read_data, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("post_rst_read_data", read_data, 32'h0);
    ref_mem[8] = 16'hF00D;   // only the low half reached the SRAM
    last_rd = 32'h0;
    access(1'b1, 1'b0, 32'd1040, 32'h0);
    idle(1);

    // Both enables: treated as a read of words 0/1
    access(1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF);
    idle(1);

    // Below-base address wraps to the top of the SRAM
    access(1'b0, 1'b1, 32'd1020, 32'h0BADCAFE);
    access(1'b1, 1'b0, 32'd1021, 32'h0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      access(op != 1, op != 0, a, $urandom);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(int'(gap));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
